// File: rtl/shift_reg_univ_nbit_if.sv
// Control/data bundle for the universal shift register: mode, serial and
// parallel inputs toward the register, contents and frame status back out.
interface shift_reg_univ_nbit_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned CW = $clog2(N) + 1;

  logic          en_in;
  logic [1:0]    mode_in;
  logic          sr_in;
  logic          sl_in;
  logic [N-1:0]  d_in;
  logic [N-1:0]  q_out;
  logic          sr_out;
  logic          sl_out;
  logic [CW-1:0] cnt_out;
  logic          done_out;

  modport slave (
    input  en_in, mode_in, sr_in, sl_in, d_in,
    output q_out, sr_out, sl_out, cnt_out, done_out
  );

  modport master (
    output en_in, mode_in, sr_in, sl_in, d_in,
    input  q_out, sr_out, sl_out, cnt_out, done_out
  );
endinterface

// File: rtl/shift_reg_univ_nbit.sv
// N-bit universal shift register (hold / shift right / shift left / load)
// with a shift counter that pulses done after every N shifts.
module shift_reg_univ_nbit #(
  parameter int unsigned N         = 4,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset_al_in,
  shift_reg_univ_nbit_if.slave  bus
);
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  logic [N-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [N-1:0]  w_q;
  logic [CW-1:0] w_cnt;
  logic          w_done;
  logic          w_shift;

  // Next-state: data path, then frame counting shared by both shift directions
  always_comb begin
    w_q     = r_q;
    w_cnt   = r_cnt;
    w_done  = 1'b0;
    w_shift = 1'b0;
    if (bus.en_in) begin
      case (mode_t'(bus.mode_in))
        MODE_RIGHT: begin
          w_q     = {bus.sr_in, r_q[N-1:1]};
          w_shift = 1'b1;
        end
        MODE_LEFT: begin
          w_q     = {r_q[N-2:0], bus.sl_in};
          w_shift = 1'b1;
        end
        MODE_LOAD: begin
          w_q   = bus.d_in;
          w_cnt = '0;
        end
        default: ;
      endcase
    end
    if (w_shift) begin
      if (r_cnt == CW'(N - 1)) begin
        w_cnt  = '0;
        w_done = 1'b1;
      end else begin
        w_cnt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_q    <= RESET_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q;
      r_cnt  <= w_cnt;
      r_done <= w_done;
    end
  end

  assign bus.q_out    = r_q;
  assign bus.sr_out   = r_q[0];
  assign bus.sl_out   = r_q[N-1];
  assign bus.cnt_out  = r_cnt;
  assign bus.done_out = r_done;
endmodule

// File: doc/shift_reg_univ_nbit.md
Name: shift_reg_univ_nbit

Overview:
Parametrised universal shift register with N-bit width. It supports hold, shift-right, shift-left and parallel-load modes, gated by a clock enable. A shift counter tracks serial frames and pulses a done flag after N shifts, so the block can serve as a serialiser (load then shift out) or a deserialiser (shift in, then read q_out). It is the general-purpose successor to the fixed-width serial-in/serial-out register in the registers library.

Parameters:
N, 4, register width in bits; legal range N >= 2
RESET_VAL, {N{1'b0}}, value of q_out during and after reset
(local) CW = $clog2(N)+1, width of cnt_out

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_al_in  input  1  asynchronous active-low reset
en_in  input  1  clock enable; when 0 all state holds
mode_in  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
sr_in  input  1  serial input for shift right; enters at MSB
sl_in  input  1  serial input for shift left; enters at LSB
d_in  input  N  parallel load data
q_out  output  N  register contents
sr_out  output  1  serial output for shift right; equals q_out[0]; combinational from register
sl_out  output  1  serial output for shift left; equals q_out[N-1]; combinational from register
cnt_out  output  CW  number of shifts since the last load or frame completion; range 0..N-1
done_out  output  1  one-cycle pulse on frame completion

Behaviour:
- Reset: reset_al_in=0 forces q_out=RESET_VAL, cnt_out=0 and done_out=0 immediately, with no clock edge needed. Outputs stay there while reset is held. This also applies mid-frame and discards any partial frame.
- The first active edge after reset release is processed normally.
- en_in=0: q_out and cnt_out hold; done_out is 0 on that edge. mode_in is ignored.
- en_in=1, mode 00: q_out and cnt_out hold; done_out is 0.
- en_in=1, mode 01: q <= {sr_in, q[N-1:1]}.
- en_in=1, mode 10: q <= {q[N-2:0], sl_in}.
- en_in=1, mode 11: q <= d_in; cnt_out <= 0; done_out <= 0.
- Shift counting: each enabled shift (mode 01 or 10) increments cnt_out, regardless of direction.
  - Changing direction mid-frame does not reset the count.
  - On the shift that takes cnt from N-1 to N, cnt_out wraps to 0 and done_out is set to 1 on that same edge.
- done_out timing: registered. It is high for exactly one cycle after the N-th shift edge and cleared on the next edge. Back-to-back frames pulse again after every further N shifts.
- Latency: q_out, cnt_out and done_out all reflect an edge's inputs immediately after that edge (1-cycle registered). sr_out and sl_out follow q_out with no extra delay.
- Only one mode applies per cycle; there is no priority conflict. Load always takes effect regardless of a partial frame and abandons that frame.
- Mode 01 with en_in held high reproduces plain SISO behaviour: q_out[0] emerges N cycles after entering at sr_in.

Test Plan:
1. Reset: reset_al_in=0 at t=0, released at t=5 with clk idle -> q_out=0000, cnt_out=0, done_out=0 before any edge. Assert reset at a non-edge time mid-run -> q_out=0000 immediately.
2. Parallel load: en_in=1, mode_in=11, d_in=1011 -> q_out=1011 after one edge, cnt_out=0, sr_out=1, sl_out=1.
3. Serialise right: from 1011, mode_in=01, sr_in=0 for four edges.
   - sr_out before each edge is 1,1,0,1.
   - q_out goes 0101, 0010, 0001, 0000.
   - cnt_out goes 1, 2, 3, 0.
   - done_out=1 only in the cycle after the 4th edge.
4. Deserialise left: from 0000, mode_in=10, sl_in=1,0,1,1 -> q_out goes 0001, 0010, 0101, 1011; done_out pulses once after the 4th shift.
5. Enable and hold: after 2 shifts, en_in=0 for 3 edges with mode_in=01 -> q_out and cnt_out=2 unchanged, done_out=0. Then mode_in=00 with en_in=1 -> still unchanged. Resume 2 shifts -> done_out pulses.
6. Abort cases:
   - After 2 shifts, mode_in=11 with d_in=0110 -> q_out=0110, cnt_out=0, no done_out pulse. The next 4 shifts produce exactly one done_out pulse.
   - Repeat the run with reset applied after 2 shifts -> q_out=0000, cnt_out=0.
